// File: rtl/led_pattern_arbiter.sv
// Round-robin arbiter sharing one LED pattern output among NUM_REQ requesters.
// Each grant latches the winner's pattern and holds it for a HOLD_CYCLES display slot.
module led_pattern_arbiter #(
   parameter int NUM_REQ     = 3,
   parameter int DATA_W      = 26,
   parameter int HOLD_CYCLES = 25000000,
   parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic                       clk_clk,
   input  logic                       reset_reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic                       busy,
   output logic [DATA_W-1:0]          leds_out
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t               state, state_d;
   logic [IDX_W-1:0]     last, last_d, owner_d;
   logic [IDX_W-1:0]     sel, sel_hi, sel_lo;
   logic                 hit_hi;
   logic [DATA_W-1:0]    pat, leds_d;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [NUM_REQ-1:0]   gnt_d;
   logic                 busy_d;

   // Rotation search: lowest requester above the last winner, else lowest overall.
   always_comb begin
      sel_hi = '0;
      sel_lo = '0;
      hit_hi = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            if (i > int'(last)) begin
               hit_hi = 1'b1;
               sel_hi = IDX_W'(i);
            end else begin
               sel_lo = IDX_W'(i);
            end
         end
      end
      sel = hit_hi ? sel_hi : sel_lo;
   end

   always_comb begin
      pat = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (sel == IDX_W'(i)) pat = req_data[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d = state;
      gnt_d   = '0;
      busy_d  = busy;
      cnt_d   = cnt;
      owner_d = owner;
      last_d  = last;
      leds_d  = leds_out;
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_d   = ONE_HOT0 << sel;
               leds_d  = pat;
               owner_d = sel;
               last_d  = sel;
               cnt_d   = CNT_W'(HOLD_CYCLES - 1);
               busy_d  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            // Requests are deliberately ignored until the slot expires.
            if (cnt == '0) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
      endcase
   end

   // Pointer resets to the top index so requester 0 wins the first arbitration.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state    <= IDLE;
         gnt      <= '0;
         busy     <= 1'b0;
         cnt      <= '0;
         owner    <= '0;
         last     <= IDX_W'(NUM_REQ - 1);
         leds_out <= '0;
      end else begin
         state    <= state_d;
         gnt      <= gnt_d;
         busy     <= busy_d;
         cnt      <= cnt_d;
         owner    <= owner_d;
         last     <= last_d;
         leds_out <= leds_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
// Self-checking bench for led_pattern_arbiter: directed scenarios plus random traffic
// compared each cycle against a slot-countdown reference model.
module tb_led_pattern_arbiter;

   localparam int N    = 3;
   localparam int W    = 26;
   localparam int HOLD = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req;
   logic [N*W-1:0]   req_data;
   logic [N-1:0]     gnt;
   logic [1:0]       owner;
   logic             busy;
   logic [W-1:0]     leds_out;

   int checks = 0;
   int errors = 0;

   logic [N-1:0]     rq;
   logic [W-1:0]     dat [N];

   // Reference model state: busy cycles remaining in the current slot, plus last outputs.
   int               rem;
   int               last_m;
   int               owner_m;
   logic [W-1:0]     leds_m;
   logic [N-1:0]     gnt_m;

   always #5 clk = ~clk;

   assign req      = rq;
   assign req_data = {dat[2], dat[1], dat[0]};

   led_pattern_arbiter #(
      .NUM_REQ    (N),
      .DATA_W     (W),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk_clk    (clk),
      .reset_reset(rst),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .owner      (owner),
      .busy       (busy),
      .leds_out   (leds_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rem     = 0;
      last_m  = N - 1;
      owner_m = 0;
      leds_m  = '0;
      gnt_m   = '0;
   endtask

   task automatic model_step();
      int w;
      if (rst) begin
         model_reset();
      end else begin
         gnt_m = '0;
         if (rem > 0) begin
            rem--;
         end else if (rq != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
               int i;
               i = (last_m + k) % N;
               if (w < 0 && rq[i]) w = i;
            end
            gnt_m   = N'(1) << w;
            leds_m  = dat[w];
            owner_m = w;
            last_m  = w;
            rem     = HOLD;
         end
      end
   endtask

   task automatic compare();
      chk("gnt",   32'(gnt),      32'(gnt_m));
      chk("busy",  32'(busy),     32'(rem > 0));
      chk("owner", 32'(owner),    32'(owner_m));
      chk("leds",  32'(leds_out), 32'(leds_m));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   task automatic wait_gnt(input int budget, input string tag, output logic [N-1:0] g);
      g = '0;
      for (int c = 0; c < budget && g == '0; c++) begin
         cyc();
         g = gnt;
      end
      if (g == '0) chk({tag, "_timeout"}, 32'(0), 32'(1));
   endtask

   initial begin
      logic [N-1:0]  g;
      logic [N-1:0]  gq[$];
      int            tq[$];
      logic [W-1:0]  lq[$];
      int            oq[$];
      int            bcnt;
      bit            seen2;
      logic [N-1:0]  exp_g [4];
      logic [W-1:0]  exp_l [4];
      int            exp_o [4];

      // Reset held with no requests, then ten idle cycles.
      rst = 1'b1;
      rq  = '0;
      for (int i = 0; i < N; i++) dat[i] = '0;
      model_reset();
      #1;
      compare();
      for (int i = 0; i < 3; i++) cyc();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      chk("rst_no_gnt", 32'(gnt), 32'(0));

      // Single request from requester 0, dropped after the grant.
      dat[0] = 26'h2AAAAAA;
      rq     = 3'b001;
      cyc();
      chk("single_gnt",  32'(gnt),      32'(3'b001));
      chk("single_leds", 32'(leds_out), 32'(26'h2AAAAAA));
      rq   = '0;
      bcnt = int'(busy);
      for (int i = 0; i < 6; i++) begin
         cyc();
         bcnt += int'(busy);
      end
      chk("single_busy_len",  32'(bcnt),     32'(HOLD));
      chk("single_hold_leds", 32'(leds_out), 32'(26'h2AAAAAA));

      // Constant requests from all three: strict rotation, one grant per slot.
      do_reset();
      for (int i = 0; i < N; i++) dat[i] = W'(i + 1);
      rq = 3'b111;
      for (int c = 0; c < 20; c++) begin
         cyc();
         if (gnt != '0) begin
            gq.push_back(gnt);
            tq.push_back(c);
            lq.push_back(leds_out);
            oq.push_back(int'(owner));
         end
      end
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_l = '{W'(1), W'(2), W'(3), W'(1)};
      exp_o = '{0, 1, 2, 0};
      chk("rr_count", 32'(gq.size()), 32'(4));
      for (int k = 0; k < 4 && k < gq.size(); k++) begin
         chk("rr_gnt",   32'(gq[k]), 32'(exp_g[k]));
         chk("rr_leds",  32'(lq[k]), 32'(exp_l[k]));
         chk("rr_owner", 32'(oq[k]), 32'(exp_o[k]));
         if (k > 0) chk("rr_period", 32'(tq[k] - tq[k-1]), 32'(HOLD + 1));
      end
      rq = '0;

      // Wrap from requester 2 back to 0, then skip the idle requester.
      do_reset();
      rq = 3'b100;
      wait_gnt(10, "ws_a", g);
      chk("ws_first", 32'(g), 32'(3'b100));
      rq = 3'b011;
      wait_gnt(10, "ws_b", g);
      chk("ws_wrap", 32'(g), 32'(3'b001));
      wait_gnt(10, "ws_c", g);
      chk("ws_next", 32'(g), 32'(3'b010));
      rq = '0;

      // One-cycle request pulse that lands entirely inside a slot is lost.
      do_reset();
      dat[0] = 26'h1234567;
      dat[2] = 26'h3FFFFFF;
      rq     = 3'b001;
      cyc();
      rq = '0;
      cyc();
      rq = 3'b100;
      cyc();
      rq    = '0;
      seen2 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (gnt[2]) seen2 = 1'b1;
      end
      chk("pulse_no_gnt2", 32'(seen2),    32'(0));
      chk("pulse_leds",    32'(leds_out), 32'(26'h1234567));

      // Reset two cycles into a slot clears outputs without waiting for a clock.
      do_reset();
      dat[0] = 26'h0F0F0F0;
      dat[1] = 26'h0ABCDEF;
      rq     = 3'b001;
      cyc();
      rq = '0;
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      chk("rstmid_busy",  32'(busy),     32'(0));
      chk("rstmid_leds",  32'(leds_out), 32'(0));
      chk("rstmid_gnt",   32'(gnt),      32'(0));
      chk("rstmid_owner", 32'(owner),    32'(0));
      model_reset();
      cyc();
      cyc();
      rst = 1'b0;
      rq  = 3'b010;
      cyc();
      chk("rstmid_regnt", 32'(gnt), 32'(3'b010));
      rq = '0;

      // Random requests, patterns and occasional resets against the model.
      for (int c = 0; c < 400; c++) begin
         rq = N'($urandom_range(0, 7));
         for (int i = 0; i < N; i++) dat[i] = W'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         cyc();
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_pattern_arbiter.md
Name: led_pattern_arbiter

Overview:
- Round-robin arbiter that shares the single 26-bit LED signal input of the Nios system (leds_new_signal) between several pattern requesters, e.g. key-handler logic, a status generator and a test-pattern source.
- Each grant latches one requester's pattern onto the shared output and holds it for a programmable display slot before re-arbitrating.
- Sits in the top level between the requester blocks and the nios_system LED input.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_W, 26, pattern width; matches the LED signal width.
- HOLD_CYCLES, 25000000, display-slot length in clk_clk cycles (0.5 s at 50 MHz); legal range is 1 or more.
- CNT_W, $clog2(HOLD_CYCLES+1), width of the slot counter; this is a derived parameter.

Ports:
- clk_clk  input  1  system clock.
- reset_reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  level request, one bit per requester.
- req_data  input  NUM_REQ*DATA_W  flat pattern bus; requester i is at [i*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant pulse, one cycle wide.
- owner  output  $clog2(NUM_REQ)  index of the requester granted most recently.
- busy  output  1  high while a display slot is active.
- leds_out  output  DATA_W  registered pattern that drives leds_new_signal.

Behaviour:
- One clock, clk_clk. Reset is asynchronous and active-high on reset_reset.
- Values while reset is asserted:
  - State machine is in IDLE.
  - gnt=0, busy=0, leds_out=0, owner=0, counter=0.
  - Internal last-grant pointer is NUM_REQ-1, so requester 0 wins first.
- IDLE state:
  - At each rising edge, if req is nonzero, select the first asserted req bit, searching from (last+1) mod NUM_REQ upward with wrap-around.
  - On that same edge: gnt<=onehot(sel), leds_out<=req_data slice for sel, owner<=sel, last<=sel, counter<=HOLD_CYCLES-1, busy<=1, state<=HOLD.
  - If req is zero: stay in IDLE; all outputs hold their values. leds_out keeps the last pattern and is not cleared.
- HOLD state:
  - gnt<=0 on the first edge in HOLD, so gnt is high for exactly one cycle.
  - At each edge, if counter==0 then state<=IDLE and busy<=0; otherwise counter decrements.
  - busy is high for exactly HOLD_CYCLES cycles, starting in the gnt cycle.
  - req and req_data are ignored throughout HOLD.
- Grant period:
  - Back-to-back grants are HOLD_CYCLES+1 cycles apart, because at least one IDLE cycle separates slots.
  - With HOLD_CYCLES=1: busy is high for 1 cycle, and the grant period is 2 cycles.
- Requester handshake:
  - Hold req and req_data stable until gnt is seen.
  - Drop req in the cycle after gnt if no further pattern is pending.
  - A req still high when the arbiter returns to IDLE counts as a new request and competes under round-robin.
- Simultaneous requests: only one grant per arbitration. Losers keep req high and are served in rotation order. No requester waits more than NUM_REQ-1 slots.
- Single persistent requester: it is re-granted every HOLD_CYCLES+1 cycles. The pointer rotation does not starve it.
- A req pulse that falls entirely inside HOLD is lost, by design. Requesters must use level requests.
- Reset asserted mid-HOLD: asynchronous return to the reset values immediately, no pending grant survives, and leds_out reads 0.
- No combinational path from req or req_data to any output; all outputs are registered.

Test Plan:
(NUM_REQ=3, DATA_W=26, HOLD_CYCLES=4)
- Reset check:
  - Stimulus: hold reset_reset high 3 cycles, req=000.
  - Required: leds_out=0, gnt=0, busy=0, owner=0 during and after reset. No grant for 10 idle cycles.
- Single request:
  - Stimulus: req=001, data0=26'h2AAAAAA, requester drops req after gnt.
  - Required: gnt=001 for exactly 1 cycle, the cycle after req is first sampled. leds_out=26'h2AAAAAA in that same cycle. busy high 4 cycles. State returns to IDLE and leds_out holds 26'h2AAAAAA.
- Round-robin order:
  - Stimulus: req=111 held constantly, data_i=i+1.
  - Required: gnt order 001, 010, 100, 001, with grants 5 cycles apart. leds_out sequence 1, 2, 3, 1; owner sequence 0, 1, 2, 0.
- Wrap and skip:
  - Stimulus: after a grant to requester 2, set req=011.
  - Required: next grant is 001; then 010.
- Ignored pulse:
  - Stimulus: 1-cycle req=100 pulse issued during HOLD of a requester-0 slot.
  - Required: no gnt to requester 2. leds_out keeps requester 0's pattern.
- Reset mid-slot:
  - Stimulus: assert reset_reset 2 cycles into HOLD.
  - Required: busy=0 and leds_out=0 immediately, without waiting for a clock edge. After release with req=010, the first gnt is 010, because the pointer was reset.
